// File: rtl/key_count_source.sv
// Pushbutton front end for the hex display: sync, debounce and
// turn press events into a registered 4-bit count.
module key_count_source #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter bit WRAP            = 1'b1
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic [3:0] KEY,
  input  logic [3:0] SW,
  output logic [3:0] VALUE,
  output logic       VALUE_STB,
  output logic [3:0] KEY_LVL
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  logic [3:0] r_s1;
  logic [3:0] r_s2;
  logic [3:0] r_st;
  logic [3:0] w_st_nxt;
  logic [3:0] w_ev;
  logic [3:0] r_value;
  logic [3:0] w_value_nxt;
  logic [3:0] w_inc;
  logic [3:0] w_dec;
  logic       r_stb;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_s1 <= 4'h0;
      r_s2 <= 4'h0;
    end else begin
      r_s1 <= ~KEY;
      r_s2 <= r_s1;
    end
  end

  // A level change needs DEBOUNCE_CYCLES back-to-back disagreeing samples.
  for (genvar g = 0; g < 4; g++) begin : g_db
    logic          w_diff;
    logic          w_done;
    logic [CW-1:0] r_cnt;

    assign w_diff      = r_s2[g] ^ r_st[g];
    assign w_done      = w_diff && (r_cnt == C_LAST);
    assign w_st_nxt[g] = r_st[g] ^ w_done;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
        r_cnt <= '0;
      end else if (!w_diff || w_done) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + C_ONE;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_st <= 4'h0;
    end else begin
      r_st <= w_st_nxt;
    end
  end

  assign w_ev = w_st_nxt & ~r_st;

  always_comb begin
    w_inc = r_value + 4'h1;
    w_dec = r_value - 4'h1;
    if (!WRAP && (r_value == 4'hF)) begin
      w_inc = 4'hF;
    end
    if (!WRAP && (r_value == 4'h0)) begin
      w_dec = 4'h0;
    end
  end

  always_comb begin
    w_value_nxt = r_value;
    if (w_ev[2]) begin
      w_value_nxt = 4'h0;
    end else if (w_ev[3]) begin
      w_value_nxt = SW;
    end else if (w_ev[0] && w_ev[1]) begin
      w_value_nxt = r_value;
    end else if (w_ev[0]) begin
      w_value_nxt = w_inc;
    end else if (w_ev[1]) begin
      w_value_nxt = w_dec;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_value <= 4'h0;
      r_stb   <= 1'b0;
    end else begin
      r_value <= w_value_nxt;
      r_stb   <= (w_value_nxt != r_value);
    end
  end

  assign VALUE     = r_value;
  assign VALUE_STB = r_stb;
  assign KEY_LVL   = r_st;

endmodule

// File: tb/tb_key_count_source.sv
// Bench for key_count_source: wrapping and saturating instances
// checked every cycle against a run-length debounce model.
module tb_key_count_source;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key = 4'hF;
  logic [3:0] sw = 4'h0;
  logic [3:0] val1, val0, lvl1, lvl0;
  logic       stb1, stb0;

  int n_chk = 0;
  int n_pass = 0;
  int n_stb1 = 0;
  int n_stb0 = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  key_count_source #(.DEBOUNCE_CYCLES(D), .WRAP(1'b1)) u_wrap (
    .CLOCK_50(clk), .RESET_N(rst_n), .KEY(key), .SW(sw),
    .VALUE(val1), .VALUE_STB(stb1), .KEY_LVL(lvl1)
  );

  key_count_source #(.DEBOUNCE_CYCLES(D), .WRAP(1'b0)) u_sat (
    .CLOCK_50(clk), .RESET_N(rst_n), .KEY(key), .SW(sw),
    .VALUE(val0), .VALUE_STB(stb0), .KEY_LVL(lvl0)
  );

  task automatic check(input string nm, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  function automatic int nextv(input int v, input logic [3:0] ev,
                               input bit wrap, input int s);
    if (ev[2]) return 0;
    if (ev[3]) return s;
    if (ev[0] && ev[1]) return v;
    if (ev[0]) return (v == 15) ? (wrap ? 0 : 15) : v + 1;
    if (ev[1]) return (v == 0) ? (wrap ? 15 : 0) : v - 1;
    return v;
  endfunction

  // model: pressed samples delayed two edges; a level flips once
  // D consecutive samples disagree with it
  logic [3:0] m_d1 = 0, m_d2 = 0, m_lvl = 0;
  int m_run[4] = '{0, 0, 0, 0};
  int m_v1 = 0, m_v0 = 0;
  bit m_stb1 = 0, m_stb0 = 0;

  always @(posedge clk or negedge rst_n) begin : b_model
    logic [3:0] ev;
    int nv;
    if (!rst_n) begin
      m_d1 = 0; m_d2 = 0; m_lvl = 0;
      for (int k = 0; k < 4; k++) m_run[k] = 0;
      m_v1 = 0; m_v0 = 0; m_stb1 = 0; m_stb0 = 0;
    end else begin
      ev = 0;
      for (int k = 0; k < 4; k++) begin
        if (m_d2[k] != m_lvl[k]) begin
          m_run[k]++;
          if (m_run[k] == D) begin
            m_lvl[k] = ~m_lvl[k];
            m_run[k] = 0;
            ev[k] = m_lvl[k];
          end
        end else begin
          m_run[k] = 0;
        end
      end
      nv = nextv(m_v1, ev, 1'b1, int'(sw));
      m_stb1 = (nv != m_v1); m_v1 = nv;
      nv = nextv(m_v0, ev, 1'b0, int'(sw));
      m_stb0 = (nv != m_v0); m_v0 = nv;
      m_d2 = m_d1;
      m_d1 = ~key;
    end
  end

  always @(posedge clk) begin
    #1;
    if (stb1) n_stb1++;
    if (stb0) n_stb0++;
    if (chk_en) begin
      check("model_val_wrap", int'(val1), m_v1);
      check("model_stb_wrap", int'(stb1), int'(m_stb1));
      check("model_lvl_wrap", int'(lvl1), int'(m_lvl));
      check("model_val_sat", int'(val0), m_v0);
      check("model_stb_sat", int'(stb0), int'(m_stb0));
      check("model_lvl_sat", int'(lvl0), int'(m_lvl));
    end
  end

  task automatic press(input logic [3:0] m);
    @(negedge clk);
    key = key & ~m;
    repeat (10) @(negedge clk);
    key = key | m;
    repeat (10) @(negedge clk);
  endtask

  int s1, s0;

  initial begin
    // reset with keys toggling
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      key = 4'($urandom);
      @(negedge clk);
    end
    check("rst_val", int'(val1), 0);
    check("rst_lvl", int'(lvl1), 0);
    check("rst_stb", int'(stb1), 0);
    key = 4'hF;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_val", int'(val1), 0);
    check("idle_lvl", int'(lvl1), 0);

    // clean press latency: edge E samples the low key
    @(negedge clk);
    key[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("lat_e4_val", int'(val1), 0);
    check("lat_e4_lvl", int'(lvl1), 0);
    @(posedge clk);
    #1;
    check("lat_e5_val", int'(val1), 1);
    check("lat_e5_stb", int'(stb1), 1);
    check("lat_e5_lvl", int'(lvl1), 1);
    @(posedge clk);
    #1;
    check("lat_e6_stb", int'(stb1), 0);
    repeat (50) @(negedge clk);
    check("hold_val", int'(val1), 1);
    key[0] = 1'b1;
    repeat (10) @(negedge clk);
    press(4'b0001);
    check("second_val", int'(val1), 2);

    // bounce, then steady low
    for (int r = 0; r < 5; r++) begin
      key[0] = 1'b0;
      repeat (3) @(negedge clk);
      key[0] = 1'b1;
      @(negedge clk);
    end
    key[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("bounce_e4", int'(val1), 2);
    @(posedge clk);
    #1;
    check("bounce_e5", int'(val1), 3);
    @(negedge clk);
    key[0] = 1'b1;
    repeat (10) @(negedge clk);

    // wrap / saturate
    press(4'b0100);
    check("clr_val", int'(val1), 0);
    press(4'b0010);
    check("dec_wrap", int'(val1), 15);
    check("dec_sat", int'(val0), 0);
    press(4'b0100);
    s1 = n_stb1; s0 = n_stb0;
    for (int i = 1; i <= 16; i++) begin
      press(4'b0001);
      check("inc_wrap", int'(val1), i % 16);
    end
    check("inc_sat", int'(val0), 15);
    check("stb_wrap_16", n_stb1 - s1, 16);
    check("stb_sat_15", n_stb0 - s0, 15);
    s0 = n_stb0;
    press(4'b0001);
    check("sat17_val", int'(val0), 15);
    check("sat17_nostb", n_stb0 - s0, 0);

    // priority
    sw = 4'd9;
    press(4'b1001);
    check("load_over_inc", int'(val1), 9);
    check("load_over_inc_s", int'(val0), 9);
    press(4'b1100);
    check("clr_over_load", int'(val1), 0);
    sw = 4'd5;
    press(4'b1000);
    check("load5", int'(val1), 5);
    s1 = n_stb1;
    press(4'b0011);
    press(4'b1000);
    check("incdec_val", int'(val1), 5);
    check("incdec_nostb", n_stb1 - s1, 0);

    // reset mid-debounce with key held
    press(4'b0100);
    @(negedge clk);
    key[1] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_val", int'(val1), 0);
    s1 = n_stb1;
    repeat (4) @(posedge clk);
    #1;
    check("mid_rst_f4", int'(val1), 0);
    repeat (2) @(posedge clk);
    #1;
    check("mid_rst_f6", int'(val1), 15);
    check("mid_rst_f6_sat", int'(val0), 0);
    @(negedge clk);
    key[1] = 1'b1;
    repeat (12) @(negedge clk);
    check("mid_rst_one_ev", n_stb1 - s1, 1);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
